// File: rtl/exception_ctrl.sv
// exception_ctrl: commit-point exception arbiter feeding CP0 at the MEM/WB boundary.
// Merges synchronous exception flags with the registered interrupt request and picks
// one event per commit. It drives the CP0 event code, bad address and redirect PC,
// then holds flush_o high for FLUSH_CYCLES cycles in total.
module exception_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [13:0] exc_flags_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    // Event codes presented to CP0; 0 means no event.
    localparam logic [31:0] EXC_INT       = 32'h0000_0001;
    localparam logic [31:0] EXC_TLBINV_I  = 32'h0000_0002;
    localparam logic [31:0] EXC_TLBINV_D  = 32'h0000_0003;
    localparam logic [31:0] EXC_ADEL_I    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES      = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
    localparam logic [31:0] EXC_RI        = 32'h0000_000A;
    localparam logic [31:0] EXC_OV        = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000E;
    localparam logic [31:0] EXC_MOD       = 32'h0000_0011;
    localparam logic [31:0] EXC_REFILL_I  = 32'h0000_0012;
    localparam logic [31:0] EXC_REFILL_D  = 32'h0000_0013;
    localparam logic [31:0] EXC_ADEL_D    = 32'h0000_0014;

    // CP0 register numbers that are forwarded from an in-flight MTC0.
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Status / Cause bit positions.
    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned ST_ERL = 2;
    localparam int unsigned ST_BEV = 22;
    localparam int unsigned CA_IV  = 23;

    localparam logic [31:0] BEV_BASE   = 32'hBFC0_0200;
    localparam logic [31:0] OFS_GEN    = 32'h0000_0180;
    localparam logic [31:0] OFS_INT_IV = 32'h0000_0200;
    localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        int_pend_q, int_pend_d;

    logic [31:0] status_fwd;
    logic [31:0] cause_fwd;
    logic [31:0] epc_fwd;

    logic [13:0] flags_v;
    logic        evt_valid;
    logic [31:0] evt_code;
    logic [31:0] evt_bad;
    logic [31:0] evt_pc;
    logic        evt_is_int;
    logic        evt_is_eret;
    logic        evt_is_refill;
    logic [31:0] vec_base;

    // Bits of CP0 words and parameters that the arbiter does not look at.
    logic        unused_bits;
    assign unused_bits = ^{RESET_PC, status_fwd, cause_fwd};

    // Passthroughs to CP0 for EPC / BadVAddr selection.
    assign current_inst_addr_o = pc_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;

    // Forward an in-flight MTC0 so same-cycle writes take effect immediately.
    always_comb begin
        status_fwd = status_i;
        cause_fwd  = cause_i;
        epc_fwd    = epc_i;
        if (cp0_we_i) begin
            if (cp0_waddr_i == CP0_STATUS) status_fwd = cp0_wdata_i;
            if (cp0_waddr_i == CP0_CAUSE)  cause_fwd  = cp0_wdata_i;
            if (cp0_waddr_i == CP0_EPC)    epc_fwd    = cp0_wdata_i;
        end
    end

    // Masked interrupt condition, sampled into int_pend_q each cycle.
    always_comb begin
        int_pend_d = (|(cause_fwd[15:8] & status_fwd[15:8])) &
                     status_fwd[ST_IE] & ~status_fwd[ST_EXL] & ~status_fwd[ST_ERL];
    end

    // Qualify flags: bubbles raise nothing, and any instruction-side fault
    // (flags 0..7) masks the data-side faults (flags 8..12).
    always_comb begin
        flags_v = inst_valid_i ? exc_flags_i : '0;
        if (|flags_v[7:0]) begin
            flags_v[12:8] = '0;
        end
    end

    // Fixed-priority selection of the single event for this commit.
    always_comb begin
        evt_valid     = 1'b1;
        evt_code      = '0;
        evt_bad       = '0;
        evt_is_int    = 1'b0;
        evt_is_eret   = 1'b0;
        evt_is_refill = 1'b0;
        if (int_pend_q && inst_valid_i) begin
            evt_code   = EXC_INT;
            evt_is_int = 1'b1;
        end else if (flags_v[0]) begin
            evt_code = EXC_ADEL_I;
            evt_bad  = pc_i;
        end else if (flags_v[1]) begin
            evt_code      = EXC_REFILL_I;
            evt_is_refill = 1'b1;
        end else if (flags_v[2]) begin
            evt_code = EXC_TLBINV_I;
        end else if (flags_v[3]) begin
            evt_code = EXC_RI;
        end else if (flags_v[4]) begin
            evt_code = EXC_OV;
        end else if (flags_v[5]) begin
            evt_code = EXC_TRAP;
        end else if (flags_v[6]) begin
            evt_code = EXC_SYSCALL;
        end else if (flags_v[7]) begin
            evt_code = EXC_BREAK;
        end else if (flags_v[8]) begin
            evt_code = EXC_ADEL_D;
            evt_bad  = mem_addr_i;
        end else if (flags_v[9]) begin
            evt_code = EXC_ADES;
            evt_bad  = mem_addr_i;
        end else if (flags_v[10]) begin
            evt_code      = EXC_REFILL_D;
            evt_is_refill = 1'b1;
        end else if (flags_v[11]) begin
            evt_code = EXC_TLBINV_D;
        end else if (flags_v[12]) begin
            evt_code = EXC_MOD;
        end else if (flags_v[13]) begin
            evt_code    = EXC_ERET;
            evt_is_eret = 1'b1;
        end else begin
            evt_valid = 1'b0;
        end
    end

    // Redirect target: EPC for ERET, otherwise the vector base plus an offset.
    always_comb begin
        vec_base = status_fwd[ST_BEV] ? BEV_BASE : ebase_i;
        if (evt_is_eret) begin
            evt_pc = epc_fwd;
        end else if (evt_is_refill && !status_fwd[ST_EXL]) begin
            evt_pc = vec_base;
        end else if (evt_is_int && cause_fwd[CA_IV]) begin
            evt_pc = vec_base + OFS_INT_IV;
        end else begin
            evt_pc = vec_base + OFS_GEN;
        end
    end

    // Flush FSM next state and outputs. Acceptance is gated by rst so that
    // asserting reset clears every output in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        new_pc_d     = new_pc_q;
        excepttype_o = '0;
        bad_addr_o   = '0;
        flush_o      = 1'b0;
        new_pc_o     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!rst && evt_valid && !stall_i) begin
                    excepttype_o = evt_code;
                    bad_addr_o   = evt_bad;
                    flush_o      = 1'b1;
                    new_pc_o     = evt_pc;
                    new_pc_d     = evt_pc;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_FLUSH: begin
                flush_o  = 1'b1;
                new_pc_o = new_pc_q;
                if (cnt_q >= FLUSH_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, flush counter, latched redirect PC and interrupt sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            new_pc_q   <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            new_pc_q   <= new_pc_d;
            int_pend_q <= int_pend_d;
        end
    end

endmodule
